seven_segment_scanner: RTL



---
 rtl/sevseg_pkg.sv | 35 +++
 rtl/seven_segment_scanner_if.sv | 21 ++
 rtl/sevseg_decode.sv | 24 ++
 rtl/seven_segment_scanner.sv | 122 ++++++++++++
 4 files changed

// File: rtl/sevseg_pkg.sv
// rtl/sevseg_pkg.sv - shared segment patterns, bit order and polarity helper for the scanner
package sevseg_pkg;

    // Segment bit positions within the {g,f,e,d,c,b,a} bus
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high glyphs
    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_LIT   = 1'b1
    } slot_phase_e;

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// rtl/seven_segment_scanner_if.sv - data/strobe and display bundle between datapath and scanner
interface seven_segment_scanner_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [DIGITS-1:0]     blank_mask;
    logic [6:0]            seg_out;
    logic [DIGITS-1:0]     dig_sel;
    logic                  err;

    modport master (
        output load, bcd_in, blank_mask,
        input  seg_out, dig_sel, err
    );

    modport slave (
        input  load, bcd_in, blank_mask,
        output seg_out, dig_sel, err
    );
endinterface

// File: rtl/sevseg_decode.sv
// rtl/sevseg_decode.sv - combinational BCD to active-high seven-segment decoder
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed seven-segment driver; SEVSEG_LZB_EN enables leading-zero blanking
module seven_segment_scanner
    import sevseg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    seven_segment_scanner_if.slave bus
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_IDLE = seg_polarity(SEG_OFF, ACTIVE_LOW);
    localparam logic [DIGITS-1:0] DIG_IDLE = ACTIVE_LOW ? '1 : '0;

    logic [4*DIGITS-1:0] latch_q;
    logic [PW-1:0]       presc_q;
    logic [IW-1:0]       idx_q;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   dig_q;
    logic                err_q;
    logic [DIGITS-1:0]   lzb_mask;

    logic [3:0]          digit_arr [DIGITS];
    logic [3:0]          cur_digit;
    logic [6:0]          dec_seg;
    logic [6:0]          seg_act;
    logic [DIGITS-1:0]   dig_act;
    logic                err_next;
    logic                presc_wrap;
    slot_phase_e         phase;

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            digit_arr[i] = latch_q[4*i +: 4];
        end
    end

    always_comb begin
        err_next = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_arr[i] > 4'd9) err_next = 1'b1;
        end
    end

    assign cur_digit  = digit_arr[idx_q];
    assign presc_wrap = (presc_q == PRE_LAST);
    assign phase      = (presc_q == '0) ? PH_BLANK : PH_LIT;

    sevseg_decode u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef SEVSEG_LZB_EN
    logic [DIGITS-1:0] lzb_next;
    logic              lzb_run;

    // Walk down from the most significant digit while it is zero; digit 0 always shows
    always_comb begin
        lzb_next = '0;
        lzb_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lzb_run && (bus.bcd_in[4*i +: 4] == 4'd0)) begin
                lzb_next[i] = 1'b1;
            end else begin
                lzb_run = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lzb_mask <= '0;
        end else if (bus.load) begin
            lzb_mask <= lzb_next;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    always_comb begin
        dig_act = '0;
        seg_act = SEG_OFF;
        if (phase == PH_LIT) begin
            dig_act[idx_q] = 1'b1;
            if (!(bus.blank_mask[idx_q] || lzb_mask[idx_q])) begin
                seg_act = dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= SEG_IDLE;
            dig_q   <= DIG_IDLE;
            err_q   <= 1'b0;
        end else begin
            if (bus.load) latch_q <= bus.bcd_in;
            presc_q <= presc_wrap ? '0 : presc_q + 1'b1;
            if (presc_wrap) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            seg_q <= seg_polarity(seg_act, ACTIVE_LOW);
            dig_q <= ACTIVE_LOW ? ~dig_act : dig_act;
            err_q <= err_next;
        end
    end

    assign bus.seg_out = seg_q;
    assign bus.dig_sel = dig_q;
    assign bus.err     = err_q;

endmodule
